// File: rtl/flit_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : flit_fifo_param
//  Brief    : Parameterised single-clock flit FIFO, registered or
//             first-word-fall-through output, status flags and sticky errors.
//  Revision : 1.0 - initial release
// ============================================================================
module flit_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 1,
    parameter int FWFT     = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              flush,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull = CNT_W'(AFULL_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_set;
    logic w_udf_set;

    assign count       = r_count;
    assign full        = (r_count == c_depth);
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= c_afull);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // A read frees the head on the same edge, so a full FIFO still takes a write.
    assign w_rd_acc  = read && !empty && !flush;
    assign w_wr_acc  = write && (!full || read) && !flush;
    assign w_ovf_set = write && full && !read;
    assign w_udf_set = read && empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Gated to zero while empty so reset shows zero without clearing storage.
            assign data_out   = empty ? '0 : r_mem[r_rd_ptr];
            assign data_valid = !empty;
        end else begin : g_registered
            logic [DATA_W-1:0] r_data_out;
            logic              r_data_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_flit_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flit_fifo_param
//  Brief    : Scoreboard bench for three flit_fifo_param configurations
//             sharing one stimulus stream, checked against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flit_fifo_param;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       write   = 1'b0;
    logic       read    = 1'b0;
    logic       flush   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = 8'h00;

    always #5 clk = ~clk;

    logic [7:0] dout [3];
    logic       dv   [3];
    logic       ful  [3];
    logic       emp  [3];
    logic       af   [3];
    logic       ovf  [3];
    logic       udf  [3];
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [2:0] cnt2;

    flit_fifo_param u_d8_reg (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .flush(flush), .err_clr(err_clr), .data_out(dout[0]), .data_valid(dv[0]),
        .full(ful[0]), .empty(emp[0]), .almost_full(af[0]), .count(cnt0),
        .overflow(ovf[0]), .underflow(udf[0])
    );

    flit_fifo_param #(.DEPTH(4), .FWFT(0)) u_d4_reg (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .flush(flush), .err_clr(err_clr), .data_out(dout[1]), .data_valid(dv[1]),
        .full(ful[1]), .empty(emp[1]), .almost_full(af[1]), .count(cnt1),
        .overflow(ovf[1]), .underflow(udf[1])
    );

    flit_fifo_param #(.DEPTH(4), .AFULL_TH(2), .FWFT(1)) u_d4_fwft (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .flush(flush), .err_clr(err_clr), .data_out(dout[2]), .data_valid(dv[2]),
        .full(ful[2]), .empty(emp[2]), .almost_full(af[2]), .count(cnt2),
        .overflow(ovf[2]), .underflow(udf[2])
    );

    int c_dep [3] = '{8, 4, 4};
    int c_th  [3] = '{7, 3, 2};
    int c_fw  [3] = '{0, 0, 1};

    int n_vec = 0;
    int n_mis = 0;

    logic [7:0] mq  [3][$];
    logic [7:0] exq [3][$];
    bit         m_ovf [3];
    bit         m_udf [3];
    bit         take;

    task automatic chk(input string nm, input int k, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s[dut%0d] @%0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp_v);
        end
    endtask

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Reference behaviour for the coming edge, applied to every configuration.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int  sz;
            bit  m_full, m_empty;
            sz      = mq[k].size();
            m_full  = (sz == c_dep[k]);
            m_empty = (sz == 0);
            if (flush) begin
                mq[k].delete();
            end else begin
                if (read && !m_empty) exq[k].push_back(mq[k].pop_front());
                if (write && (!m_full || read)) mq[k].push_back(data_in);
            end
            if (write && m_full && !read) m_ovf[k] = 1'b1;
            else if (err_clr)             m_ovf[k] = 1'b0;
            if (read && m_empty)          m_udf[k] = 1'b1;
            else if (err_clr)             m_udf[k] = 1'b0;
        end
    endtask

    task automatic check_flags();
        for (int k = 0; k < 3; k++) begin
            int m;
            m = mq[k].size();
            chk("count",       k, cnt_of(k),    m);
            chk("full",        k, int'(ful[k]), int'(m == c_dep[k]));
            chk("empty",       k, int'(emp[k]), int'(m == 0));
            chk("almost_full", k, int'(af[k]),  int'(m >= c_th[k]));
            chk("overflow",    k, int'(ovf[k]), int'(m_ovf[k]));
            chk("underflow",   k, int'(udf[k]), int'(m_udf[k]));
            if (c_fw[k] != 0) chk("fwft_valid", k, int'(dv[k]), int'(m != 0));
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_count",    k, cnt_of(k),     0);
            chk("rst_full",     k, int'(ful[k]),  0);
            chk("rst_empty",    k, int'(emp[k]),  1);
            chk("rst_afull",    k, int'(af[k]),   0);
            chk("rst_valid",    k, int'(dv[k]),   0);
            chk("rst_data_out", k, int'(dout[k]), 0);
            chk("rst_overflow", k, int'(ovf[k]),  0);
            chk("rst_underflow",k, int'(udf[k]),  0);
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        write   = w;
        data_in = d;
        read    = r;
        flush   = f;
        err_clr = c;
        model_step();
        @(posedge clk);
        #1;
        check_flags();
    endtask

    task automatic reset_mid_cycle();
        #2 rst = 1'b0;
        #1 check_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            exq[k].delete();
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Registered mode: any data_valid pulse is a delivered flit.
    // FWFT mode: a flit is delivered when the presented head is popped.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            take = (c_fw[k] != 0) ? (dv[k] && read && !flush && rst) : dv[k];
            if (take) begin
                if (exq[k].size() == 0) chk("spurious_valid", k, int'(dv[k]), 0);
                else                    chk("data_out", k, int'(dout[k]), int'(exq[k].pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 check_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_mid_cycle();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) chk("undelivered", k, exq[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
